sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Sequencer that turns the team's simple dual-port SRAM into a synchronous FIFO with valid/ready handshakes on both sides.
- The SRAM has one write port, one read port, registered read data and one-cycle read latency.
- This block owns the SRAM pointers, write enable, occupancy count and read-latency compensation. The SRAM is instantiated outside this block and connected through the ram_* ports.
- Used as the standard buffer between streaming stages of the synthesis test designs.

Parameters:
- DATA_WIDTH, 8, word width; must match the SRAM.
- ADDR_WIDTH, 8, SRAM address width; DEPTH = 2**ADDR_WIDTH entries.
- AF_LEVEL, 2**ADDR_WIDTH-2, almost_full threshold; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  push data.
- in_valid  in  1  push request.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  DATA_WIDTH  head word; combinational from ram_q.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts the head word.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL (optional feature).
- ram_data  out  DATA_WIDTH  to SRAM data.
- ram_write_addr  out  ADDR_WIDTH  to SRAM write_addr.
- ram_we  out  1  to SRAM we.
- ram_read_addr  out  ADDR_WIDTH  to SRAM read_addr.
- ram_q  in  DATA_WIDTH  from SRAM q.

Behaviour:
- Reset (async, while rst=1):
  - wr_ptr, rd_ptr and count are 0.
  - out_valid=0, in_ready=1, almost_full=0.
  - Any push or pop in flight is discarded; contents become don't-care.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- On push:
  - ram_we=1, ram_write_addr=wr_ptr, ram_data=in_data, all combinational in the same cycle.
  - wr_ptr increments modulo DEPTH.
- On pop: rd_ptr increments modulo DEPTH.
- ram_read_addr = rd_ptr + pop (modulo DEPTH), i.e. the head address for the next cycle. ram_q is therefore ram[rd_ptr] in every cycle.
- Read-after-write hazard: the SRAM returns old data when the same address is written in the same cycle. A word pushed at edge E therefore drives out_valid only after edge E+1.
  - Push-to-out_valid latency into an empty FIFO: 2 cycles.
  - The block keeps a registered "readable" count, equal to count excluding the word pushed in the previous cycle. out_valid = readable != 0.
- in_ready = (count != DEPTH), from registered state only, with no combinational path from out_ready.
  - When full, a simultaneous pop does not admit a push in that cycle.
- count = count + push - pop. Simultaneous push and pop leaves count unchanged; pointers still advance.
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer compare.
- Sustained throughput: 1 word per cycle on both sides when neither is stalled.
- out_data holds stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no data loss or duplication under any combination of in_valid and out_ready.

Optional Feature:
- Macro SRAM_FIFO_ALMOST_FULL_EN.
- Defined: almost_full is registered, = (count_next >= AF_LEVEL), and updates in the same cycle as count.
- Undefined: almost_full is tied to 0 and the AF_LEVEL logic is absent. The port remains present for a stable interface.

Decomposition:
- Shared package sram_fifo_pkg holds:
  - a localparam function for DEPTH from ADDR_WIDTH;
  - the count width constant (ADDR_WIDTH+1);
  - the default AF_LEVEL derivation.
- One natural sub-module, fifo_ptr: a modulo-DEPTH pointer with increment enable and async reset, instantiated for wr_ptr and rd_ptr.
- The SRAM stays external; benches instantiate the SRAM alongside the controller.

Test Plan (ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3):
- Reset, then push 0x11 one cycle with out_ready=1 -> out_valid rises 2 cycles after the push edge, out_data=0x11, count returns 1->0 on the pop.
- Push 0xA0..0xA3 back-to-back with out_ready=0 -> count=4, in_ready=0; the 5th in_valid is not accepted; almost_full=1 from count=3 (macro on) or 0 (macro off).
- Continuous push 0x00..0x0F with out_ready=1 -> outputs 0x00..0x0F in order at 1/cycle after a 2-cycle initial latency; pointers wrap 4 times; count ≤ 2.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> pop occurs, no push that cycle, count=3; the push is accepted the following cycle.
- Random in_valid and out_ready (50%) for 1000 cycles -> scoreboard: exact order, no loss or duplication, count always equals pushes minus pops, out_data stable while stalled.
- Assert rst mid-stream with count=2 -> outputs immediately go to reset values (out_valid=0, count=0, in_ready=1); after release, push 0x5A -> out_data=0x5A with no stale words.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared sizing helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Occupancy needs one extra bit so that the full count DEPTH is representable.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  function automatic int unsigned af_level_default(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd2;
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready stream bundle; master drives data/valid, slave drives ready.
interface sram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/sram_fifo_ctrl_fifo_ptr.sv
// Modulo-2**ADDR_WIDTH pointer with increment enable and async reset.
module fifo_ptr #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO sequencer around an external 1-cycle-latency dual-port SRAM.
// Optional registered almost_full_o under macro SRAM_FIFO_ALMOST_FULL_EN.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = af_level_default(ADDR_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  sram_fifo_ctrl_if.slave                  in_i,
  sram_fifo_ctrl_if.master                 out_o,
  output logic [cnt_width(ADDR_WIDTH)-1:0] count_o,
  output logic                             almost_full_o,
  output logic [DATA_WIDTH-1:0]            ram_data_o,
  output logic [ADDR_WIDTH-1:0]            ram_write_addr_o,
  output logic                             ram_we_o,
  output logic [ADDR_WIDTH-1:0]            ram_read_addr_o,
  input  logic [DATA_WIDTH-1:0]            ram_q_i
);
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CW    = cnt_width(ADDR_WIDTH);

  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rdbl_q, rdbl_d;
  logic                  push_q;
  logic                  in_ready, out_valid, push, pop;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (rdbl_q != '0);
  assign push      = in_i.valid & in_ready;
  assign pop       = out_valid & out_o.ready;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  // A word written last cycle is not yet readable: the SRAM returned old data
  // for that address, so it joins the readable count one cycle late.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    rdbl_d = rdbl_q + CW'(push_q) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rdbl_q  <= '0;
      push_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      rdbl_q  <= rdbl_d;
      push_q  <= push;
    end
  end

`ifdef SRAM_FIFO_ALMOST_FULL_EN
  logic af_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= (count_d >= CW'(AF_LEVEL));
  end
  assign almost_full_o = af_q;
`else
  assign almost_full_o = 1'b0;
`endif

  assign in_i.ready       = in_ready;
  assign out_o.valid      = out_valid;
  assign out_o.data       = ram_q_i;
  assign count_o          = count_q;
  assign ram_we_o         = push;
  assign ram_data_o       = in_i.data;
  assign ram_write_addr_o = wr_ptr;
  // Look ahead so the registered SRAM output always holds the next head word.
  assign ram_read_addr_o  = rd_ptr + ADDR_WIDTH'(pop);
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench: controller plus behavioural SRAM against a queue model.
module tb_sram_fifo_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW)) in_bus ();
  sram_fifo_ctrl_if #(.DATA_WIDTH(DW)) out_bus ();

  logic [AW:0]   count;
  logic          af;
  logic [DW-1:0] ram_data, ram_q;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_i             (in_bus),
    .out_o            (out_bus),
    .count_o          (count),
    .almost_full_o    (af),
    .ram_data_o       (ram_data),
    .ram_write_addr_o (ram_wa),
    .ram_we_o         (ram_we),
    .ram_read_addr_o  (ram_ra),
    .ram_q_i          (ram_q)
  );

  // External SRAM: registered read, old data on same-address write.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_data;
    ram_q <= mem[ram_ra];
  end

  typedef struct {
    logic [7:0] d;
    int         c;
  } ent_t;

  ent_t q[$];
  int   cyc    = 0;
  int   pushes = 0;
  int   pops   = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against model, drive inputs, advance model.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
    bit e_ir, e_ov, push, pop;
    @(negedge clk);
    e_ir = (q.size() != DEPTH);
    e_ov = 1'b0;
    if (q.size() > 0) e_ov = (q[0].c <= cyc - 2);
    chk("in_ready", in_bus.ready, e_ir);
    chk("out_valid", out_bus.valid, e_ov);
    chk("count", count, q.size());
`ifdef SRAM_FIFO_ALMOST_FULL_EN
    chk("almost_full", af, q.size() >= AF);
`else
    chk("almost_full", af, 0);
`endif
    if (e_ov) chk("out_data", out_bus.data, q[0].d);
    in_bus.valid  = iv;
    in_bus.data   = d;
    out_bus.ready = ordy;
    push = iv && e_ir;
    pop  = ordy && e_ov;
    #1;
    chk("ram_we", ram_we, push);
    if (push) begin
      chk("ram_write_addr", ram_wa, pushes % DEPTH);
      chk("ram_data", ram_data, d);
    end
    chk("ram_read_addr", ram_ra, (pops + int'(pop)) % DEPTH);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (push) begin
      q.push_back('{d: d, c: cyc});
      pushes++;
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_bus.valid, 0);
    chk("rst_in_ready", in_bus.ready, 1);
    chk("rst_count", count, 0);
    chk("rst_af", af, 0);
    rst = 1'b0;

    // Single word: visible two cycles after it is offered.
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    #1;
    chk("lat_out_valid", out_bus.valid, 1);
    chk("lat_out_data", out_bus.data, 8'h11);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Fill to full with consumer stalled; fifth offer must be refused.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    step(1'b1, 8'hA4, 1'b0);
    #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_bus.ready, 0);

    // Full with simultaneous pop: only the pop happens, push lands next cycle.
    step(1'b1, 8'hB0, 1'b1);
    #1;
    chk("fullpop_count", count, 3);
    step(1'b1, 8'hB0, 1'b1);
    #1;
    chk("fullpop_refill_count", count, 3);
    repeat (8) step(1'b0, 8'h00, 1'b1);

    // Continuous streaming with wrap-around.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b1);
      #1;
      chk("stream_count_le2", count <= 2, 1);
    end
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (8) step(1'b0, 8'h00, 1'b1);
    chk("random_balance", pushes - pops, q.size());

    // Asynchronous reset mid-stream with two readable words.
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #1;
    chk("pre_rst_count", count, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_bus.valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_bus.ready, 1);
    chk("mid_rst_af", af, 0);
    q.delete();
    pushes = 0;
    pops   = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #1;
    chk("post_rst_out_data", out_bus.data, 8'h5A);
    chk("post_rst_count", count, 1);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
